cons_memory: RTL and testbench

Heap memory for the Lisp machine: a 4096 × 16-bit word store with one read port and one cons-allocation port. A cons request writes a car/cdr pair into the next two free words and returns a pointer to the pair. The evaluator core uses the read port to walk lists, and the cons port to build cells.

---
 rtl/cons_memory_pkg.sv | 9 +
 rtl/cons_memory_ram.sv | 23 ++
 rtl/cons_memory.sv | 105 ++++++++++
 tb/tb_cons_memory.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/cons_memory_pkg.sv
// cons_memory_pkg: shared widths, heap bounds and cons FSM state type for the cons heap.
package cons_memory_pkg;
  localparam int ADDR_W = 12;
  localparam int WORD_W = 16;
  localparam logic [ADDR_W-1:0] HEAP_BASE = 12'h002;
  localparam logic [ADDR_W-1:0] HEAP_LIMIT = 12'hFFE;
  localparam logic [WORD_W-1:0] NIL_PTR = 16'h0000;
  typedef enum logic {IDLE, WR_CDR} cons_state_e;
endpackage

// File: rtl/cons_memory_ram.sv
// cons_memory_ram: 2^ADDR_W x WORD_W simple dual-port RAM, read-first, registered read.
// Ports: clk; we_i/waddr_i/wdata_i write port; re_i/raddr_i read request;
//        rdata_o registered read data, holds between reads.
module cons_memory_ram #(
  parameter int ADDR_W = 12,
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WORD_W-1:0] rdata_o
);
  logic [WORD_W-1:0] mem_q [2**ADDR_W];
  logic [WORD_W-1:0] rdata_q;
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/cons_memory.sv
// cons_memory: Lisp heap with a read port and a two-cycle cons allocator.
// Ports: clk; rst sync active-low; req/addr_in read request; data_ready/data_out read result;
//        cons_en/cons_car/cons_cdr cons request; cons_done/cons_ptr new cell pointer (nil on OOM).
// Option: define CONS_MEM_FORWARD_EN for write-to-read forwarding on same-cycle address match.
module cons_memory #(
  parameter int ADDR_W = cons_memory_pkg::ADDR_W,
  parameter int WORD_W = cons_memory_pkg::WORD_W,
  parameter logic [ADDR_W-1:0] HEAP_BASE = cons_memory_pkg::HEAP_BASE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr_in,
  output logic              data_ready,
  output logic [WORD_W-1:0] data_out,
  input  logic              cons_en,
  input  logic [WORD_W-1:0] cons_car,
  input  logic [WORD_W-1:0] cons_cdr,
  output logic              cons_done,
  output logic [WORD_W-1:0] cons_ptr
);
  import cons_memory_pkg::*;
  cons_state_e state_q, state_d;
  // one extra bit so the pointer can reach 2^ADDR_W after the last cell without wrapping
  logic [ADDR_W:0] free_q, free_d;
  logic [WORD_W-1:0] cdr_q, cdr_d, ptr_q, ptr_d, wdata, rdata;
  logic [ADDR_W-1:0] waddr;
  logic oom_q, oom_d, done_q, done_d, rdy_q, vld_q, we, oom_now;
  assign oom_now = free_q > (ADDR_W+1)'(HEAP_LIMIT);
  always_comb begin
    state_d = state_q;
    free_d = free_q;
    cdr_d = cdr_q;
    ptr_d = ptr_q;
    oom_d = oom_q;
    done_d = 1'b0;
    we = 1'b0;
    waddr = free_q[ADDR_W-1:0];
    wdata = cons_car;
    if (state_q == IDLE) begin
      if (cons_en) begin
        state_d = WR_CDR;
        cdr_d = cons_cdr;
        oom_d = oom_now;
        we = !oom_now;
      end
    end else begin
      // an out-of-memory request still passes through WR_CDR so its reply has the same latency
      state_d = IDLE;
      done_d = 1'b1;
      we = !oom_q;
      waddr = free_q[ADDR_W-1:0] + 1'b1;
      wdata = cdr_q;
      ptr_d = oom_q ? NIL_PTR : WORD_W'(free_q[ADDR_W-1:0]);
      free_d = oom_q ? free_q : free_q + (ADDR_W+1)'(2);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      free_q <= {1'b0, HEAP_BASE};
      oom_q <= 1'b0;
      done_q <= 1'b0;
      ptr_q <= '0;
      rdy_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      free_q <= free_d;
      oom_q <= oom_d;
      done_q <= done_d;
      ptr_q <= ptr_d;
      rdy_q <= req;
      vld_q <= vld_q | req;
    end
    cdr_q <= cdr_d;
  end
  cons_memory_ram #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) u_ram (
    .clk    (clk),
    .we_i   (we),
    .waddr_i(waddr),
    .wdata_i(wdata),
    .re_i   (req),
    .raddr_i(addr_in),
    .rdata_o(rdata)
  );
`ifdef CONS_MEM_FORWARD_EN
  logic hit_q;
  logic [WORD_W-1:0] fwd_q;
  always_ff @(posedge clk) begin
    if (!rst) hit_q <= 1'b0;
    else if (req) begin
      hit_q <= we && (waddr == addr_in);
      fwd_q <= wdata;
    end
  end
  assign data_out = !vld_q ? '0 : hit_q ? fwd_q : rdata;
`else
  // vld_q masks the uninitialised RAM output register until the first read after reset
  assign data_out = vld_q ? rdata : '0;
`endif
  assign data_ready = rdy_q;
  assign cons_done = done_q;
  assign cons_ptr = ptr_q;
endmodule

// File: tb/tb_cons_memory.sv
// tb_cons_memory: directed self-checking bench for cons_memory.
module tb_cons_memory;
  logic clk = 1'b0;
  logic rst, req, cons_en, data_ready, cons_done;
  logic [11:0] addr_in;
  logic [15:0] data_out, cons_car, cons_cdr, cons_ptr;
  int n_vec = 0;
  int n_err = 0;

  cons_memory dut (
    .clk(clk), .rst(rst), .req(req), .addr_in(addr_in),
    .data_ready(data_ready), .data_out(data_out),
    .cons_en(cons_en), .cons_car(cons_car), .cons_cdr(cons_cdr),
    .cons_done(cons_done), .cons_ptr(cons_ptr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cons(input logic [15:0] car, input logic [15:0] cdr, input logic [15:0] exp_ptr, input string tag);
    cons_en = 1'b1;
    cons_car = car;
    cons_cdr = cdr;
    step();
    cons_en = 1'b0;
    check({tag, "_done_early"}, {15'd0, cons_done}, 16'd0);
    step();
    check({tag, "_done"}, {15'd0, cons_done}, 16'd1);
    check({tag, "_ptr"}, cons_ptr, exp_ptr);
  endtask

  task automatic do_read(input logic [11:0] a, input logic [15:0] exp, input string tag);
    req = 1'b1;
    addr_in = a;
    step();
    req = 1'b0;
    check({tag, "_ready"}, {15'd0, data_ready}, 16'd1);
    check({tag, "_data"}, data_out, exp);
  endtask

  task automatic pulse_reset(input string tag);
    rst = 1'b0;
    step();
    rst = 1'b1;
    check({tag, "_done"}, {15'd0, cons_done}, 16'd0);
    check({tag, "_ptr"}, cons_ptr, 16'd0);
    check({tag, "_ready"}, {15'd0, data_ready}, 16'd0);
    check({tag, "_data"}, data_out, 16'd0);
  endtask

  initial begin
    rst = 1'b0;
    req = 1'b0;
    cons_en = 1'b0;
    addr_in = '0;
    cons_car = '0;
    cons_cdr = '0;
    step();
    pulse_reset("por");

    do_cons(16'hDEAD, 16'hBEEF, 16'h0002, "seq0");
    do_cons(16'h1234, 16'h5678, 16'h0004, "seq1");
    do_cons(16'hABCD, 16'hEF01, 16'h0006, "seq2");
    step();
    check("done_pulse", {15'd0, cons_done}, 16'd0);
    check("ptr_hold", cons_ptr, 16'h0006);

    do_read(12'd2, 16'hDEAD, "rd2");
    do_read(12'd3, 16'hBEEF, "rd3");
    do_read(12'd4, 16'h1234, "rd4");
    do_read(12'd5, 16'h5678, "rd5");
    do_read(12'd6, 16'hABCD, "rd6");
    do_read(12'd7, 16'hEF01, "rd7");
    step();
    check("ready_pulse", {15'd0, data_ready}, 16'd0);
    check("data_hold", data_out, 16'hEF01);

    pulse_reset("rst");
    do_cons(16'h1111, 16'h2222, 16'h0002, "rst_cons");
    do_read(12'd2, 16'h1111, "rst_rd2");
    do_read(12'd3, 16'h2222, "rst_rd3");

    cons_en = 1'b1;
    cons_car = 16'hAAAA;
    cons_cdr = 16'hBBBB;
    step();
    cons_car = 16'hCCCC;
    cons_cdr = 16'hDDDD;
    step();
    cons_en = 1'b0;
    check("busy_done", {15'd0, cons_done}, 16'd1);
    check("busy_ptr", cons_ptr, 16'h0004);
    step();
    check("busy_single", {15'd0, cons_done}, 16'd0);
    do_cons(16'h1357, 16'h2468, 16'h0006, "busy_next");
    do_read(12'd4, 16'hAAAA, "busy_rd4");
    do_read(12'd5, 16'hBBBB, "busy_rd5");

    pulse_reset("rst2");
    cons_en = 1'b1;
    cons_car = 16'h5555;
    cons_cdr = 16'h6666;
    req = 1'b1;
    addr_in = 12'd2;
    step();
    cons_en = 1'b0;
    req = 1'b0;
    check("fwd_ready", {15'd0, data_ready}, 16'd1);
`ifdef CONS_MEM_FORWARD_EN
    check("fwd_data", data_out, 16'h5555);
`else
    check("fwd_data", data_out, 16'h1111);
`endif
    step();
    check("fwd_done", {15'd0, cons_done}, 16'd1);
    check("fwd_ptr", cons_ptr, 16'h0002);
    do_read(12'd2, 16'h5555, "fwd_rd2");
    do_read(12'd3, 16'h6666, "fwd_rd3");

    pulse_reset("rst3");
    for (int i = 0; i < 2047; i++) begin
      cons_en = 1'b1;
      cons_car = 16'(i);
      cons_cdr = ~16'(i);
      step();
      cons_en = 1'b0;
      step();
    end
    check("fill_done", {15'd0, cons_done}, 16'd1);
    check("fill_last_ptr", cons_ptr, 16'h0FFE);
    do_cons(16'h9999, 16'h8888, 16'h0000, "oom0");
    do_read(12'hFFE, 16'h07FE, "oom_rdFFE");
    do_read(12'hFFF, 16'hF801, "oom_rdFFF");
    do_read(12'h002, 16'h0000, "oom_rd2");
    do_cons(16'h7777, 16'h6666, 16'h0000, "oom1");
    do_read(12'hFFE, 16'h07FE, "oom_rdFFE2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
